// File: rtl/memwrite_checker_if.sv
// Bundle between a write-port checker and whatever drives it: table load,
// run control, snooped core write port and the checker's status.
interface memwrite_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [WIDTH-1:0] cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [CNT_W-1:0] cfg_count;
  logic [WIDTH-1:0] ign_base;
  logic [WIDTH-1:0] ign_limit;
  logic             start;
  logic             memwrite;
  logic [WIDTH-1:0] dataadr;
  logic [WIDTH-1:0] writedata;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] match_cnt;
  logic [15:0]      ign_cnt;
  logic [WIDTH-1:0] err_adr;
  logic [WIDTH-1:0] err_data;

  modport master (
    output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, ign_base, ign_limit,
           start, memwrite, dataadr, writedata,
    input  busy, pass, fail, fail_code, match_cnt, ign_cnt, err_adr, err_data
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, ign_base, ign_limit,
           start, memwrite, dataadr, writedata,
    output busy, pass, fail, fail_code, match_cnt, ign_cnt, err_adr, err_data
  );
endinterface

// File: rtl/memwrite_checker.sv
// Checks every core data-memory write against a loadable table of expected
// (address, data) pairs, ordered or unordered, with ignore window and timeout.
module memwrite_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096,
  parameter int ORDERED = 1
) (
  input logic               clk,
  input logic               reset,
  memwrite_checker_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] hit_reg, hit_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
  logic [15:0]      ign_cnt_reg, ign_cnt_next;
  logic [31:0]      cyc_reg, cyc_next;
  logic [1:0]       code_reg, code_next;
  logic [WIDTH-1:0] err_adr_reg, err_adr_next;
  logic [WIDTH-1:0] err_data_reg, err_data_next;

  logic [DEPTH-1:0] cand;
  logic             hit_found;
  logic [IDX_W-1:0] hit_idx;
  logic             in_window;

  // The table is cleared on reset, so it lives in flops rather than RAM.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!reset) begin
          addr_mem[gi] <= '0;
          data_mem[gi] <= '0;
        end else if (bus.cfg_we && state_reg != RUN && bus.cfg_idx == IDX_W'(gi)) begin
          addr_mem[gi] <= bus.cfg_addr;
          data_mem[gi] <= bus.cfg_data;
        end
      end

      assign cand[gi] = (CNT_W'(gi) < count_reg) && !hit_reg[gi] &&
                        (addr_mem[gi] == bus.dataadr) && (data_mem[gi] == bus.writedata);
    end
  endgenerate

  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    if (ORDERED != 0) begin
      hit_found = (addr_mem[ptr_reg] == bus.dataadr) && (data_mem[ptr_reg] == bus.writedata);
      hit_idx   = ptr_reg;
    end else begin
      // Scan downwards so the lowest unclaimed matching entry wins.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (cand[i]) begin
          hit_found = 1'b1;
          hit_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign in_window = (bus.dataadr >= bus.ign_base) && (bus.dataadr <= bus.ign_limit);

  always_comb begin
    state_next     = state_reg;
    hit_next       = hit_reg;
    ptr_next       = ptr_reg;
    count_next     = count_reg;
    match_cnt_next = match_cnt_reg;
    ign_cnt_next   = ign_cnt_reg;
    cyc_next       = cyc_reg;
    code_next      = code_reg;
    err_adr_next   = err_adr_reg;
    err_data_next  = err_data_reg;

    case (state_reg)
      RUN: begin
        cyc_next = cyc_reg + 32'd1;
        if (bus.memwrite) begin
          if (hit_found) begin
            match_cnt_next    = match_cnt_reg + 1'b1;
            ptr_next          = ptr_reg + 1'b1;
            hit_next[hit_idx] = 1'b1;
            if (match_cnt_next == count_reg) state_next = PASS;
          end else if (in_window) begin
            if (ign_cnt_reg != 16'hFFFF) ign_cnt_next = ign_cnt_reg + 16'd1;
          end else begin
            state_next    = FAIL;
            code_next     = 2'd1;
            err_adr_next  = bus.dataadr;
            err_data_next = bus.writedata;
          end
        end
        // Only a write that ends the run beats an expiring timer.
        if (TIMEOUT != 0 && state_next == RUN && cyc_reg == 32'(TIMEOUT - 1)) begin
          state_next = FAIL;
          code_next  = 2'd2;
        end
      end
      default: begin
        if (bus.start) begin
          hit_next       = '0;
          ptr_next       = '0;
          count_next     = bus.cfg_count;
          match_cnt_next = '0;
          ign_cnt_next   = '0;
          cyc_next       = '0;
          code_next      = 2'd0;
          err_adr_next   = '0;
          err_data_next  = '0;
          if (bus.cfg_count > CNT_W'(DEPTH)) begin
            state_next = FAIL;
            code_next  = 2'd3;
          end else if (bus.cfg_count == '0) begin
            state_next = PASS;
          end else begin
            state_next = RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      hit_reg       <= '0;
      ptr_reg       <= '0;
      count_reg     <= '0;
      match_cnt_reg <= '0;
      ign_cnt_reg   <= '0;
      cyc_reg       <= '0;
      code_reg      <= 2'd0;
      err_adr_reg   <= '0;
      err_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      hit_reg       <= hit_next;
      ptr_reg       <= ptr_next;
      count_reg     <= count_next;
      match_cnt_reg <= match_cnt_next;
      ign_cnt_reg   <= ign_cnt_next;
      cyc_reg       <= cyc_next;
      code_reg      <= code_next;
      err_adr_reg   <= err_adr_next;
      err_data_reg  <= err_data_next;
    end
  end

  assign bus.busy      = (state_reg == RUN);
  assign bus.pass      = (state_reg == PASS);
  assign bus.fail      = (state_reg == FAIL);
  assign bus.fail_code = code_reg;
  assign bus.match_cnt = match_cnt_reg;
  assign bus.ign_cnt   = ign_cnt_reg;
  assign bus.err_adr   = err_adr_reg;
  assign bus.err_data  = err_data_reg;
endmodule

// File: tb/tb_memwrite_checker.sv
// Drives an ordered and an unordered checker with identical stimulus and
// compares their status against a queue of expected results.
module tb_memwrite_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [2:0]  cfg_count;
  logic [31:0] ign_base, ign_limit;
  logic        start;
  logic        memwrite;
  logic [31:0] dataadr, writedata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    bit          sel;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [2:0]  mc;
    logic [15:0] ic;
    logic [31:0] ea;
    logic [31:0] ed;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  memwrite_checker_if #(.WIDTH(32), .DEPTH(4)) ifo ();
  memwrite_checker_if #(.WIDTH(32), .DEPTH(4)) ifu ();

  assign ifo.cfg_we = cfg_we;       assign ifu.cfg_we = cfg_we;
  assign ifo.cfg_idx = cfg_idx;     assign ifu.cfg_idx = cfg_idx;
  assign ifo.cfg_addr = cfg_addr;   assign ifu.cfg_addr = cfg_addr;
  assign ifo.cfg_data = cfg_data;   assign ifu.cfg_data = cfg_data;
  assign ifo.cfg_count = cfg_count; assign ifu.cfg_count = cfg_count;
  assign ifo.ign_base = ign_base;   assign ifu.ign_base = ign_base;
  assign ifo.ign_limit = ign_limit; assign ifu.ign_limit = ign_limit;
  assign ifo.start = start;         assign ifu.start = start;
  assign ifo.memwrite = memwrite;   assign ifu.memwrite = memwrite;
  assign ifo.dataadr = dataadr;     assign ifu.dataadr = dataadr;
  assign ifo.writedata = writedata; assign ifu.writedata = writedata;

  memwrite_checker #(.WIDTH(32), .DEPTH(4), .TIMEOUT(16), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .bus(ifo.slave)
  );

  memwrite_checker #(.WIDTH(32), .DEPTH(4), .TIMEOUT(16), .ORDERED(0)) u_unord (
    .clk(clk), .reset(reset), .bus(ifu.slave)
  );

  task automatic cmp(string tag, string field, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic expect_one(string tag, bit sel, logic busy, logic pass, logic fail,
                            logic [1:0] code, logic [2:0] mc, logic [15:0] ic,
                            logic [31:0] ea, logic [31:0] ed);
    exp_t e;
    e.tag = tag; e.sel = sel; e.busy = busy; e.pass = pass; e.fail = fail;
    e.code = code; e.mc = mc; e.ic = ic; e.ea = ea; e.ed = ed;
    sb.push_back(e);
  endtask

  task automatic expect_both(string tag, logic busy, logic pass, logic fail,
                             logic [1:0] code, logic [2:0] mc, logic [15:0] ic,
                             logic [31:0] ea, logic [31:0] ed);
    expect_one({tag, "/ord"}, 1'b0, busy, pass, fail, code, mc, ic, ea, ed);
    expect_one({tag, "/unord"}, 1'b1, busy, pass, fail, code, mc, ic, ea, ed);
  endtask

  task automatic check_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 1'b0) begin
        cmp(e.tag, "busy", 32'(ifo.busy), 32'(e.busy));
        cmp(e.tag, "pass", 32'(ifo.pass), 32'(e.pass));
        cmp(e.tag, "fail", 32'(ifo.fail), 32'(e.fail));
        cmp(e.tag, "fail_code", 32'(ifo.fail_code), 32'(e.code));
        cmp(e.tag, "match_cnt", 32'(ifo.match_cnt), 32'(e.mc));
        cmp(e.tag, "ign_cnt", 32'(ifo.ign_cnt), 32'(e.ic));
        cmp(e.tag, "err_adr", ifo.err_adr, e.ea);
        cmp(e.tag, "err_data", ifo.err_data, e.ed);
      end else begin
        cmp(e.tag, "busy", 32'(ifu.busy), 32'(e.busy));
        cmp(e.tag, "pass", 32'(ifu.pass), 32'(e.pass));
        cmp(e.tag, "fail", 32'(ifu.fail), 32'(e.fail));
        cmp(e.tag, "fail_code", 32'(ifu.fail_code), 32'(e.code));
        cmp(e.tag, "match_cnt", 32'(ifu.match_cnt), 32'(e.mc));
        cmp(e.tag, "ign_cnt", 32'(ifu.ign_cnt), 32'(e.ic));
        cmp(e.tag, "err_adr", ifu.err_adr, e.ea);
        cmp(e.tag, "err_data", ifu.err_data, e.ed);
      end
      $display("check %s: busy=%0b pass=%0b fail=%0b code=%0d", e.tag, e.busy, e.pass, e.fail, e.code);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    check_all();
  endtask

  task automatic cfg_entry(logic [1:0] idx, logic [31:0] a, logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_step(logic [2:0] cnt);
    cfg_count = cnt; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wr_step(logic [31:0] a, logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    cfg_count = 3'd1; ign_base = 32'd80; ign_limit = 32'd80; start = 1'b0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;

    tick();
    expect_both("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b1;

    // Ignored write then the single expected write.
    cfg_entry(2'd0, 32'd84, 32'd7);
    expect_both("t1_start", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd1);
    expect_both("t1_ign", 1, 0, 0, 0, 0, 1, 0, 0);
    wr_step(32'd80, 32'd5);
    expect_both("t1_match", 0, 1, 0, 0, 1, 1, 0, 0);
    wr_step(32'd84, 32'd7);

    // Unexpected write latches FAIL; later matches cannot undo it.
    expect_both("t2_start", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd1);
    expect_both("t2_bad", 0, 0, 1, 1, 0, 0, 88, 1);
    wr_step(32'd88, 32'd1);
    expect_both("t2_hold", 0, 0, 1, 1, 0, 0, 88, 1);
    wr_step(32'd84, 32'd7);

    // Timeout lands on the 16th RUN edge.
    expect_both("t3_start", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd1);
    for (int i = 0; i < 15; i++) begin
      expect_both("t3_wait", 1, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    expect_both("t3_timeout", 0, 0, 1, 2, 0, 0, 0, 0);
    step();

    // A final match on the expiry edge wins over the timeout.
    expect_both("t3b_start", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd1);
    for (int i = 0; i < 15; i++) begin
      expect_both("t3b_wait", 1, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
    expect_both("t3b_match", 0, 1, 0, 0, 1, 0, 0, 0);
    wr_step(32'd84, 32'd7);

    // Out-of-order writes: ordered checker fails, unordered passes.
    cfg_entry(2'd1, 32'd88, 32'd9);
    expect_both("t4_start", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd2);
    expect_one("t4_w1/ord", 0, 0, 0, 1, 1, 0, 0, 88, 9);
    expect_one("t4_w1/unord", 1, 1, 0, 0, 0, 1, 0, 0, 0);
    wr_step(32'd88, 32'd9);
    expect_one("t4_w2/ord", 0, 0, 0, 1, 1, 0, 0, 88, 9);
    expect_one("t4_w2/unord", 1, 0, 1, 0, 0, 2, 0, 0, 0);
    wr_step(32'd84, 32'd7);

    // Repeating an already-matched write is unexpected.
    expect_both("dup_start", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd2);
    expect_both("dup_first", 1, 0, 0, 0, 1, 0, 0, 0);
    wr_step(32'd84, 32'd7);
    expect_both("dup_again", 0, 0, 1, 1, 1, 0, 84, 7);
    wr_step(32'd84, 32'd7);

    // Count boundaries.
    expect_both("t5_badcfg", 0, 0, 1, 3, 0, 0, 0, 0);
    start_step(3'd5);
    expect_both("t5_zero", 0, 1, 0, 0, 0, 0, 0, 0);
    start_step(3'd0);

    // Reset mid-run clears everything including the table.
    expect_both("t6_start", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd2);
    expect_both("t6_match", 1, 0, 0, 0, 1, 0, 0, 0);
    wr_step(32'd84, 32'd7);
    reset = 1'b0; start = 1'b1; memwrite = 1'b1; dataadr = 32'd88; writedata = 32'd9;
    expect_both("t6_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b1; start = 1'b0; memwrite = 1'b0;
    cfg_entry(2'd0, 32'd84, 32'd7);
    expect_both("t6_restart", 1, 0, 0, 0, 0, 0, 0, 0);
    start_step(3'd2);
    expect_both("t6_reloaded", 1, 0, 0, 0, 1, 0, 0, 0);
    wr_step(32'd84, 32'd7);
    expect_both("t6_zeroed", 0, 1, 0, 0, 2, 0, 0, 0);
    wr_step(32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
